// File: rtl/button_debounce.sv
// Push-button conditioner: per-bit 2-FF synchronizer, counter debouncer,
// and registered press / release / long-press pulses.
`timescale 1ns/1ps
module button_debounce #(
  parameter int unsigned BTN         = 4,
  parameter int unsigned CLKFREQ     = 100,
  parameter int unsigned DEBOUNCE_US = 10000,
  parameter int unsigned LONG_US     = 1000000,
  parameter int unsigned ACTIVE_LOW  = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [BTN-1:0] btn_in,
  output logic [BTN-1:0] btn_level,
  output logic [BTN-1:0] btn_press,
  output logic [BTN-1:0] btn_release,
  output logic [BTN-1:0] btn_long
);

  localparam int unsigned DbCycles   = CLKFREQ * DEBOUNCE_US;
  localparam int unsigned LongCycles = CLKFREQ * LONG_US;
  localparam int unsigned CntW       = (DbCycles > 2) ? $clog2(DbCycles) : 1;
  localparam int unsigned HoldW      = (LongCycles > 1) ? $clog2(LongCycles + 1) : 1;

  localparam logic [CntW-1:0]  DbLast   = CntW'(DbCycles - 1);
  localparam logic [HoldW-1:0] HoldMax  = HoldW'(LongCycles);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LongCycles - 1);

  logic [BTN-1:0] pin;
  logic [BTN-1:0] sync1_q, sync_q;
  logic [BTN-1:0] level_q, press_q, release_q, long_q;
  logic [BTN-1:0] expire, rise, fall, long_hit;
  logic [CntW-1:0]  cnt_q  [BTN];
  logic [HoldW-1:0] hold_q [BTN];

  assign pin = (ACTIVE_LOW != 0) ? ~btn_in : btn_in;

  always_comb begin
    expire   = '0;
    long_hit = '0;
    for (int unsigned i = 0; i < BTN; i++) begin
      expire[i] = (sync_q[i] != level_q[i]) && (cnt_q[i] == DbLast);
    end
    rise = expire & sync_q;
    fall = expire & ~sync_q;
    // A release landing on the long-press edge suppresses the long pulse.
    for (int unsigned i = 0; i < BTN; i++) begin
      long_hit[i] = level_q[i] && !fall[i] && (hold_q[i] == HoldLast);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync_q    <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      for (int unsigned i = 0; i < BTN; i++) begin
        cnt_q[i]  <= '0;
        hold_q[i] <= '0;
      end
    end else begin
      sync1_q   <= pin;
      sync_q    <= sync1_q;
      level_q   <= (level_q | rise) & ~fall;
      press_q   <= rise;
      release_q <= fall;
      long_q    <= long_hit;
      for (int unsigned i = 0; i < BTN; i++) begin
        if ((sync_q[i] == level_q[i]) || expire[i]) begin
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CntW'(1);
        end
        // Level is 0 on the press edge, so this also clears hold there.
        if (!level_q[i]) begin
          hold_q[i] <= '0;
        end else if (hold_q[i] < HoldMax) begin
          hold_q[i] <= hold_q[i] + HoldW'(1);
        end
      end
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_long    = long_q;

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: window-based reference model compared every cycle,
// plus directed checks with hand-computed expectations.
`timescale 1ns/1ps
module tb_button_debounce;

  localparam int DB   = 8;
  localparam int LONG = 40;
  localparam int HN   = DB + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in0, in1;
  logic [3:0] lvl0, press0, rel0, long0;
  logic [3:0] lvl1, press1, rel1, long1;

  always #5 clk = ~clk;

  button_debounce #(
    .BTN(4), .CLKFREQ(1), .DEBOUNCE_US(DB), .LONG_US(LONG), .ACTIVE_LOW(0)
  ) dut0 (
    .clk(clk), .rst(rst), .btn_in(in0),
    .btn_level(lvl0), .btn_press(press0), .btn_release(rel0), .btn_long(long0)
  );

  button_debounce #(
    .BTN(4), .CLKFREQ(1), .DEBOUNCE_US(DB), .LONG_US(LONG), .ACTIVE_LOW(1)
  ) dut1 (
    .clk(clk), .rst(rst), .btn_in(in1),
    .btn_level(lvl1), .btn_press(press1), .btn_release(rel1), .btn_long(long1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit model_valid = 1'b0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: pin history per edge; the synchronized value lags two
  // edges, and the level flips once DB consecutive synced samples disagree.
  logic [3:0] hist [2][HN];
  logic [3:0] m_level [2];
  logic [3:0] m_press [2];
  logic [3:0] m_rel   [2];
  logic [3:0] m_long  [2];
  int         press_cyc [2][4];
  bit         armed     [2][4];
  logic [3:0] mp, all_hi, any_hi, m_rise, m_fall;

  always @(posedge clk) begin
    cyc++;
    if (rst) model_valid = 1'b1;
    for (int d = 0; d < 2; d++) begin
      mp = (d == 1) ? ~in1 : in0;
      if (rst) begin
        for (int k = 0; k < HN; k++) hist[d][k] = '0;
        m_level[d] = '0;
        m_press[d] = '0;
        m_rel[d]   = '0;
        m_long[d]  = '0;
        for (int i = 0; i < 4; i++) armed[d][i] = 1'b0;
      end else begin
        for (int k = HN - 1; k > 0; k--) hist[d][k] = hist[d][k-1];
        hist[d][0] = mp;
        all_hi = '1;
        any_hi = '0;
        for (int k = 2; k < HN; k++) begin
          all_hi = all_hi & hist[d][k];
          any_hi = any_hi | hist[d][k];
        end
        m_rise = ~m_level[d] & all_hi;
        m_fall = m_level[d] & ~any_hi;
        for (int i = 0; i < 4; i++) begin
          m_long[d][i] = m_level[d][i] && !m_fall[i] && armed[d][i] &&
                         (cyc - press_cyc[d][i] == LONG);
          if (m_long[d][i]) armed[d][i] = 1'b0;
          if (m_rise[i]) begin
            armed[d][i]     = 1'b1;
            press_cyc[d][i] = cyc;
          end
          if (m_fall[i]) armed[d][i] = 1'b0;
        end
        m_press[d] = m_rise;
        m_rel[d]   = m_fall;
        m_level[d] = (m_level[d] | m_rise) & ~m_fall;
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("model level0",   lvl0,   m_level[0]);
      check("model press0",   press0, m_press[0]);
      check("model release0", rel0,   m_rel[0]);
      check("model long0",    long0,  m_long[0]);
      check("model level1",   lvl1,   m_level[1]);
      check("model press1",   press1, m_press[1]);
      check("model release1", rel1,   m_rel[1]);
      check("model long1",    long1,  m_long[1]);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    in0 = 4'h0;
    in1 = 4'hF;
    tick(3);
    rst = 1'b0;
    check("reset level0", lvl0, 4'b0000);
    check("reset press0", press0, 4'b0000);
    check("reset long0", long0, 4'b0000);
    check("reset level1 active-low held", lvl1, 4'b0000);

    // Press and hold bit 0: press after 10 edges, long 40 after that, once.
    in0[0] = 1'b1;
    tick(9);  check("t1 level before debounce", lvl0, 4'b0000);
    tick(1);  check("t1 press", press0, 4'b0001);
              check("t1 level", lvl0, 4'b0001);
    tick(1);  check("t1 press one cycle", press0, 4'b0000);
    tick(38); check("t1 long not early", long0, 4'b0000);
    tick(1);  check("t1 long", long0, 4'b0001);
    tick(1);  check("t1 long one cycle", long0, 4'b0000);
    tick(50); check("t1 no repeat long", long0, 4'b0000);
    in0[0] = 1'b0;
    tick(12);

    // Glitches shorter than the debounce window on bit 1.
    in0[1] = 1'b1; tick(7);
    in0[1] = 1'b0; tick(3);
    in0[1] = 1'b1; tick(7);
    in0[1] = 1'b0; tick(3);
    check("glitch level stays 0", lvl0, 4'b0000);
    in0[1] = 1'b1;
    tick(9);  check("glitch final run early", lvl0, 4'b0000);
    tick(1);  check("glitch final run press", press0, 4'b0010);
    // Release 20 cycles after press: release 10 later, no long.
    tick(20); in0[1] = 1'b0;
    tick(9);  check("rel level still held", lvl0, 4'b0010);
    tick(1);  check("rel pulse", rel0, 4'b0010);
              check("rel level", lvl0, 4'b0000);
    tick(50); check("rel no long", long0, 4'b0000);

    // Debounced fall lands exactly on the long-press edge of bit 2.
    in0[2] = 1'b1;
    tick(10); check("fall-on-long press", press0, 4'b0100);
    tick(30); in0[2] = 1'b0;
    tick(9);  check("fall-on-long before", long0, 4'b0000);
    tick(1);  check("fall-on-long release", rel0, 4'b0100);
              check("fall-on-long no long", long0, 4'b0000);
    tick(5);

    // Reset mid-hold on bit 3, input kept high.
    in0[3] = 1'b1;
    tick(10); check("rst press", press0, 4'b1000);
    tick(25); rst = 1'b1;
    tick(1);  check("rst level cleared", lvl0, 4'b0000);
              check("rst no release pulse", rel0, 4'b0000);
    rst = 1'b0;
    tick(9);  check("rst re-press early", lvl0, 4'b0000);
    tick(1);  check("rst re-press", press0, 4'b1000);
    tick(39); check("rst long early", long0, 4'b0000);
    tick(1);  check("rst long", long0, 4'b1000);
    in0[3] = 1'b0;
    tick(12);

    // Simultaneous events on two bits.
    in0 = 4'b1010;
    tick(10); check("par press", press0, 4'b1010);
              check("par level", lvl0, 4'b1010);
    tick(1);  check("par press one cycle", press0, 4'b0000);
    in0 = 4'b0000;
    tick(10); check("par release", rel0, 4'b1010);

    // Active-low instance: pull bit 2 low.
    in1 = 4'b1011;
    tick(9);  check("al early", lvl1, 4'b0000);
    tick(1);  check("al press", press1, 4'b0100);
              check("al level", lvl1, 4'b0100);
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
